// File: rtl/stc_a_compressor.sv
// stc_a_compressor
//   Upstream loader for the sparse-A operand buffer. Accepts one dense A row
//   per valid/ready handshake, scans it LANES elements per cycle, packs the
//   nonzeros left-aligned together with their column indices, then writes the
//   packed data and packed column indices into the A buffer on two
//   consecutive cycles. Also reports the row's nnz and a running row-start
//   pointer (prefix sum of nnz within the current tile).
//
//   Ports
//     clk, reset      clock; synchronous active-high reset
//     in_valid/ready  dense-row handshake (ready only while idle)
//     in_row, in_idx  dense row (element j at [j*DW_DATA +: DW_DATA]), target row index
//     write_data_en   data write strobe      (A_data_input valid)
//     write_cidx_en   col-index write strobe (A_colidx_input valid)
//     A_data_input    packed nonzeros, slot s at [s*DW_DATA +: DW_DATA]
//     A_colidx_input  packed columns,  slot s at [s*DW_COL +: DW_COL]
//     idx             row index of the current write
//     nnz_valid       1-cycle pulse with nnz / row_start
//     nnz, row_start  nonzero count of the row, prefix sum of earlier rows
module stc_a_compressor #(
  parameter int K       = 16,
  parameter int DW_DATA = 16,
  parameter int DW_COL  = 4,
  parameter int DW_MEM  = 256,
  parameter int DW_PTR  = 8,
  parameter int DW_IDX  = 4,
  parameter int LANES   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DW_MEM-1:0]     in_row,
  input  logic [DW_IDX-1:0]     in_idx,
  output logic                  write_data_en,
  output logic                  write_cidx_en,
  output logic [DW_MEM-1:0]     A_data_input,
  output logic [DW_MEM-1:0]     A_colidx_input,
  output logic [DW_IDX-1:0]     idx,
  output logic                  nnz_valid,
  output logic [$clog2(K):0]    nnz,
  output logic [DW_PTR-1:0]     row_start
);

  localparam int NBEAT  = K / LANES;
  localparam int BW     = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam int DW_NNZ = $clog2(K) + 1;
  localparam int BEAT_W = LANES * DW_DATA;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_WDATA, S_WCIDX} state_t;

  state_t                r_state;
  logic                  r_in_ready;
  logic [DW_MEM-1:0]     r_row;
  logic [DW_IDX-1:0]     r_idx_lat;
  logic [BW-1:0]         r_beat;
  logic [DW_NNZ-1:0]     r_cnt;
  logic [K*DW_DATA-1:0]  r_pack_data;
  logic [K*DW_COL-1:0]   r_pack_col;
  logic                  r_wde;
  logic                  r_wce;
  logic [DW_MEM-1:0]     r_a_data;
  logic [DW_MEM-1:0]     r_a_col;
  logic [DW_IDX-1:0]     r_idx;
  logic                  r_nnz_valid;
  logic [DW_NNZ-1:0]     r_nnz;
  logic [DW_PTR-1:0]     r_row_start;
  logic [DW_PTR-1:0]     r_sum;

  logic [BEAT_W-1:0]     w_beat_row;
  logic [K*DW_DATA-1:0]  w_pack_data;
  logic [K*DW_COL-1:0]   w_pack_col;
  logic [DW_NNZ-1:0]     w_cnt;
  logic [DW_PTR-1:0]     w_start;

  // One scan beat: append this beat's nonzeros after the slots already used.
  // The running count is threaded through the lane loop so order is preserved.
  always_comb begin
    w_beat_row  = BEAT_W'(r_row >> (32'(r_beat) * LANES * DW_DATA));
    w_pack_data = r_pack_data;
    w_pack_col  = r_pack_col;
    w_cnt       = r_cnt;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (w_beat_row[l*DW_DATA +: DW_DATA] != '0) begin
        w_pack_data[32'(w_cnt)*DW_DATA +: DW_DATA] = w_beat_row[l*DW_DATA +: DW_DATA];
        w_pack_col[32'(w_cnt)*DW_COL +: DW_COL]    = DW_COL'(32'(r_beat) * LANES + l);
        w_cnt = w_cnt + DW_NNZ'(1);
      end
    end
  end

  // Row index 0 starts a new tile, restarting the prefix sum.
  always_comb begin
    w_start = (r_idx_lat == '0) ? '0 : r_sum;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_row       <= '0;
      r_idx_lat   <= '0;
      r_beat      <= '0;
      r_cnt       <= '0;
      r_pack_data <= '0;
      r_pack_col  <= '0;
      r_wde       <= 1'b0;
      r_wce       <= 1'b0;
      r_a_data    <= '0;
      r_a_col     <= '0;
      r_idx       <= '0;
      r_nnz_valid <= 1'b0;
      r_nnz       <= '0;
      r_row_start <= '0;
      r_sum       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_in_ready <= 1'b1;
          if (in_valid && r_in_ready) begin
            r_row       <= in_row;
            r_idx_lat   <= in_idx;
            r_beat      <= '0;
            r_cnt       <= '0;
            r_pack_data <= '0;
            r_pack_col  <= '0;
            r_in_ready  <= 1'b0;
            r_state     <= S_SCAN;
          end
        end
        S_SCAN: begin
          r_pack_data <= w_pack_data;
          r_pack_col  <= w_pack_col;
          r_cnt       <= w_cnt;
          r_beat      <= r_beat + BW'(1);
          if (r_beat == BW'(NBEAT - 1)) begin
            // Last beat feeds the data output directly so WDATA needs no extra cycle.
            r_a_data <= DW_MEM'(w_pack_data);
            r_idx    <= r_idx_lat;
            r_wde    <= 1'b1;
            r_state  <= S_WDATA;
          end
        end
        S_WDATA: begin
          r_wde       <= 1'b0;
          r_wce       <= 1'b1;
          r_a_col     <= DW_MEM'(r_pack_col);
          r_nnz_valid <= 1'b1;
          r_nnz       <= r_cnt;
          r_row_start <= w_start;
          r_sum       <= w_start + DW_PTR'(r_cnt);
          r_state     <= S_WCIDX;
        end
        S_WCIDX: begin
          r_wce       <= 1'b0;
          r_nnz_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready       = r_in_ready;
  assign write_data_en  = r_wde;
  assign write_cidx_en  = r_wce;
  assign A_data_input   = r_a_data;
  assign A_colidx_input = r_a_col;
  assign idx            = r_idx;
  assign nnz_valid      = r_nnz_valid;
  assign nnz            = r_nnz;
  assign row_start      = r_row_start;

endmodule

// File: tb/tb_stc_a_compressor.sv
// Bench for stc_a_compressor: stimulus tasks push expected rows into a
// scoreboard queue at accept time; a monitor pops and compares on the strobes.
module tb_stc_a_compressor;

  localparam int K = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [255:0] in_row = '0;
  logic [3:0]   in_idx = '0;
  logic         write_data_en;
  logic         write_cidx_en;
  logic [255:0] A_data_input;
  logic [255:0] A_colidx_input;
  logic [3:0]   idx;
  logic         nnz_valid;
  logic [4:0]   nnz;
  logic [7:0]   row_start;

  stc_a_compressor #(.K(16), .DW_DATA(16), .DW_COL(4), .DW_MEM(256),
                     .DW_PTR(8), .DW_IDX(4), .LANES(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_row(in_row), .in_idx(in_idx), .write_data_en(write_data_en),
    .write_cidx_en(write_cidx_en), .A_data_input(A_data_input),
    .A_colidx_input(A_colidx_input), .idx(idx), .nnz_valid(nnz_valid),
    .nnz(nnz), .row_start(row_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] data;
    logic [255:0] col;
    logic [3:0]   idx;
    logic [4:0]   nnz;
    logic [7:0]   start;
  } exp_t;

  exp_t       sbq[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] m_sum = '0;

  function automatic exp_t model_row(input logic [255:0] row, input logic [3:0] ridx);
    exp_t        e;
    int unsigned s;
    logic [15:0] v;
    e.data = '0;
    e.col  = '0;
    s      = 0;
    for (int j = 0; j < K; j++) begin
      v = row[j*16 +: 16];
      if (v != 16'h0) begin
        e.data[s*16 +: 16] = v;
        e.col[s*4 +: 4]    = 4'(j);
        s++;
      end
    end
    e.idx   = ridx;
    e.nnz   = 5'(s);
    e.start = (ridx == 4'd0) ? 8'd0 : m_sum;
    m_sum   = e.start + 8'(s);
    return e;
  endfunction

  function automatic logic [255:0] make_row(input logic [15:0] mask);
    logic [255:0] r;
    r = '0;
    for (int j = 0; j < K; j++)
      if (mask[j]) r[j*16 +: 16] = 16'($urandom_range(1, 65535));
    return r;
  endfunction

  // Scoreboard monitor, sampling 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (write_data_en && write_cidx_en) begin
      checks++; errors++;
      $display("FAIL both_strobes: data_en=%b cidx_en=%b required not both 1", write_data_en, write_cidx_en);
    end
    if (write_data_en) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_data_strobe: got write_data_en=1 required 0");
      end else if (A_data_input !== sbq[0].data || idx !== sbq[0].idx) begin
        errors++;
        $display("FAIL wdata: got data=%h idx=%0d required data=%h idx=%0d",
                 A_data_input, idx, sbq[0].data, sbq[0].idx);
      end
    end
    if (write_cidx_en) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_cidx_strobe: got write_cidx_en=1 required 0");
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if (A_colidx_input !== e.col || idx !== e.idx || nnz_valid !== 1'b1 ||
            nnz !== e.nnz || row_start !== e.start) begin
          errors++;
          $display("FAIL wcidx: got col=%h idx=%0d nv=%b nnz=%0d start=%0d required col=%h idx=%0d nv=1 nnz=%0d start=%0d",
                   A_colidx_input, idx, nnz_valid, nnz, row_start, e.col, e.idx, e.nnz, e.start);
        end
      end
    end else if (nnz_valid !== 1'b0) begin
      checks++; errors++;
      $display("FAIL nnz_valid_alone: got nnz_valid=%b required 0", nnz_valid);
    end
  end

  // Called 1 unit after an edge; returns 1 unit after the accept edge.
  task automatic send_row(input logic [255:0] row, input logic [3:0] ridx,
                          input bit push, input bit hold, output int waited);
    in_row   = row;
    in_idx   = ridx;
    in_valid = 1'b1;
    waited   = 0;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1; waited++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got in_ready=0 after %0d cycles required 1", waited);
      in_valid = 1'b0;
    end else begin
      @(posedge clk); #1; waited++;
      if (push) sbq.push_back(model_row(row, ridx));
      if (!hold) in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sbq.size() != 0 || !in_ready) && n < 40) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (sbq.size() != 0 || !in_ready) begin
      errors++;
      $display("FAIL drain_timeout: got pending=%0d in_ready=%b required 0 and 1", sbq.size(), in_ready);
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    in_valid = 1'b1;
    in_row   = make_row(16'hFFFF);
    in_idx   = 4'd5;
    repeat (2) begin
      @(posedge clk); #1;
      checks++;
      if ({in_ready, write_data_en, write_cidx_en, nnz_valid} !== 4'b0 ||
          A_data_input !== '0 || A_colidx_input !== '0 || idx !== 4'd0 ||
          nnz !== 5'd0 || row_start !== 8'd0) begin
        errors++;
        $display("FAIL reset_outputs: got rdy=%b wde=%b wce=%b nv=%b idx=%0d nnz=%0d start=%0d required all 0",
                 in_ready, write_data_en, write_cidx_en, nnz_valid, idx, nnz, row_start);
      end
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    m_sum    = '0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b required 1", in_ready);
    end
  endtask

  task automatic test_full_row();
    logic [255:0] row;
    int           w, n;
    for (int j = 0; j < K; j++) row[j*16 +: 16] = 16'(j + 1);
    send_row(row, 4'd0, 1'b1, 1'b0, w);
    n = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (write_data_en === 1'b1) begin n = c; break; end
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL wdata_latency: got %0d cycles required 4", n);
    end
    @(posedge clk); #1;
    checks++;
    if (write_cidx_en !== 1'b1 || write_data_en !== 1'b0) begin
      errors++;
      $display("FAIL wcidx_timing: got wce=%b wde=%b required 1 0", write_cidx_en, write_data_en);
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || write_cidx_en !== 1'b0 || A_data_input !== row) begin
      errors++;
      $display("FAIL ready_and_hold: got rdy=%b wce=%b data=%h required 1 0 %h",
               in_ready, write_cidx_en, A_data_input, row);
    end
  endtask

  task automatic test_sparse();
    logic [255:0] row;
    int           w;
    row = '0;
    row[2*16 +: 16]  = 16'h3C00;
    row[5*16 +: 16]  = 16'h4000;
    row[11*16 +: 16] = 16'h4200;
    send_row(row, 4'd1, 1'b1, 1'b0, w);
    wait_idle();
    checks++;
    if (A_data_input !== 256'h4200_4000_3C00 || A_colidx_input !== 256'hB52 ||
        nnz !== 5'd3 || row_start !== 8'd16) begin
      errors++;
      $display("FAIL sparse_held: got data=%h col=%h nnz=%0d start=%0d required 420040003c00 b52 3 16",
               A_data_input, A_colidx_input, nnz, row_start);
    end
  endtask

  task automatic test_zero_and_sign();
    logic [255:0] row;
    int           w;
    send_row('0, 4'd2, 1'b1, 1'b0, w);
    wait_idle();
    row = '0;
    row[15*16 +: 16] = 16'h8000;
    send_row(row, 4'd3, 1'b1, 1'b0, w);
    wait_idle();
    checks++;
    if (A_data_input !== 256'h8000 || A_colidx_input !== 256'hF || nnz !== 5'd1) begin
      errors++;
      $display("FAIL sign_only: got data=%h col=%h nnz=%0d required 8000 f 1",
               A_data_input, A_colidx_input, nnz);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] masks [4];
    int          w;
    masks[0] = 16'h0841; masks[1] = 16'hFFFF; masks[2] = 16'h0000; masks[3] = 16'h421A;
    for (int r = 0; r < 4; r++) begin
      send_row(make_row(masks[r]), 4'(r), 1'b1, 1'b1, w);
      if (r > 0) begin
        checks++;
        if (w != 7) begin
          errors++;
          $display("FAIL b2b_spacing: row %0d got %0d cycles required 7", r, w);
        end
      end
    end
    in_valid = 1'b0;
    wait_idle();
    checks++;
    if (row_start !== 8'd19 || nnz !== 5'd5) begin
      errors++;
      $display("FAIL b2b_last: got start=%0d nnz=%0d required 19 5", row_start, nnz);
    end
  endtask

  task automatic test_reset_mid_scan();
    int w, strobes;
    send_row(make_row(16'h0841), 4'd0, 1'b1, 1'b0, w);
    wait_idle();
    send_row(make_row(16'hFFFF), 4'd1, 1'b0, 1'b0, w);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_sum = '0;
    checks++;
    if ({in_ready, write_data_en, write_cidx_en, nnz_valid} !== 4'b0 ||
        A_data_input !== '0 || nnz !== 5'd0 || row_start !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got rdy=%b wde=%b wce=%b nv=%b nnz=%0d start=%0d required all 0",
               in_ready, write_data_en, write_cidx_en, nnz_valid, nnz, row_start);
    end
    strobes = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (write_data_en || write_cidx_en) strobes++;
    end
    checks++;
    if (strobes != 0) begin
      errors++;
      $display("FAIL aborted_row_strobes: got %0d required 0", strobes);
    end
    send_row(make_row(16'h0101), 4'd1, 1'b1, 1'b0, w);
    wait_idle();
    checks++;
    if (row_start !== 8'd0 || nnz !== 5'd2) begin
      errors++;
      $display("FAIL start_after_reset: got start=%0d nnz=%0d required 0 2", row_start, nnz);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_full_row();
    test_sparse();
    test_zero_and_sign();
    test_back_to_back();
    test_reset_mid_scan();
    repeat (3) begin @(posedge clk); #1; end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
